// File: rtl/bit_input_mem.sv
// bit_input_mem: copies a fixed 16-byte message ROM into a RAM (LOAD), then
// streams the RAM back out (STREAM), either forever or for one pass (HALT).
module bit_input_mem #(
  parameter bit LOOP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [3:0] addr,
  output logic [7:0] bit_out,
  output logic [7:0] byte_out,
  output logic       loaded,
  output logic       done
);

  typedef enum logic [1:0] {LOAD, STREAM, HALT} state_t;

  state_t     state, state_nxt;
  logic [3:0] addr_nxt;
  logic [7:0] byte_nxt;
  logic       loaded_nxt, done_nxt, wr;
  logic [7:0] mem [16];

  // message ROM "BIT REVERSAL TST", indexed by the live address
  always_comb begin
    case (addr)
      4'd0:  bit_out = 8'h42;
      4'd1:  bit_out = 8'h49;
      4'd2:  bit_out = 8'h54;
      4'd3:  bit_out = 8'h20;
      4'd4:  bit_out = 8'h52;
      4'd5:  bit_out = 8'h45;
      4'd6:  bit_out = 8'h56;
      4'd7:  bit_out = 8'h45;
      4'd8:  bit_out = 8'h52;
      4'd9:  bit_out = 8'h53;
      4'd10: bit_out = 8'h41;
      4'd11: bit_out = 8'h4C;
      4'd12: bit_out = 8'h20;
      4'd13: bit_out = 8'h54;
      4'd14: bit_out = 8'h53;
      default: bit_out = 8'h54;
    endcase
  end

  // next-state and next-output decode; en=0 and HALT leave everything as is
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    byte_nxt   = byte_out;
    loaded_nxt = loaded;
    done_nxt   = done;
    wr         = 1'b0;
    if (en) begin
      case (state)
        LOAD: begin
          wr       = 1'b1;
          byte_nxt = bit_out;
          addr_nxt = addr + 4'd1;          // 15 wraps to 0 for the read pass
          if (addr == 4'd15) begin
            loaded_nxt = 1'b1;
            state_nxt  = STREAM;
          end
        end
        STREAM: begin
          byte_nxt = mem[addr];
          addr_nxt = addr + 4'd1;
          if (addr == 4'd15 && !LOOP) begin
            addr_nxt  = addr;              // park on the last byte
            done_nxt  = 1'b1;
            state_nxt = HALT;
          end
        end
        default: ;
      endcase
    end
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOAD;
      addr     <= 4'd0;
      byte_out <= 8'h00;
      loaded   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      byte_out <= byte_nxt;
      loaded   <= loaded_nxt;
      done     <= done_nxt;
    end
  end

  // RAM write port; contents are not reset, every word is written before any read
  always_ff @(posedge clk) begin
    if (wr) mem[addr] <= bit_out;
  end

endmodule

// File: tb/tb_bit_input_mem.sv
// Scoreboard bench: driver pushes expected output snapshots for both a LOOP=1
// and a LOOP=0 instance; a negedge monitor pops and compares them.
module tb_bit_input_mem;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] addr [2];
  logic [7:0] bit_out [2];
  logic [7:0] byte_out [2];
  logic       loaded [2];
  logic       done [2];

  always #5 clk = ~clk;

  bit_input_mem #(.LOOP(1'b1)) dut_loop (
    .clk(clk), .reset(reset), .en(en), .addr(addr[1]), .bit_out(bit_out[1]),
    .byte_out(byte_out[1]), .loaded(loaded[1]), .done(done[1])
  );
  bit_input_mem #(.LOOP(1'b0)) dut_once (
    .clk(clk), .reset(reset), .en(en), .addr(addr[0]), .bit_out(bit_out[0]),
    .byte_out(byte_out[0]), .loaded(loaded[0]), .done(done[0])
  );

  typedef struct {
    string      name;
    int         dut;
    logic [3:0] addr;
    logic [7:0] bit_out;
    logic [7:0] byte_out;
    logic       loaded;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   drv_done = 1'b0;

  logic [7:0] msg [16] = '{8'h42, 8'h49, 8'h54, 8'h20, 8'h52, 8'h45, 8'h56, 8'h45,
                           8'h52, 8'h53, 8'h41, 8'h4C, 8'h20, 8'h54, 8'h53, 8'h54};

  // k = enabled edges since reset release
  task automatic push_exp(input string name, input int k);
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e.name = name; e.dut = d;
      e.done = 1'b0;
      if (k == 0) begin
        e.addr = 4'd0; e.byte_out = 8'h00; e.loaded = 1'b0;
      end else if (k <= 16) begin
        e.addr = 4'(k % 16); e.byte_out = msg[k-1]; e.loaded = (k == 16);
      end else if (d == 0 && k >= 32) begin
        e.addr = 4'd15; e.byte_out = msg[15]; e.loaded = 1'b1; e.done = 1'b1;
      end else begin
        e.addr = 4'((k - 16) % 16); e.byte_out = msg[(k - 17) % 16]; e.loaded = 1'b1;
      end
      e.bit_out = msg[e.addr];
      q.push_back(e);
    end
  endtask

  task automatic cmp(input string name, input int d, input string fld,
                     input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d %s: got %h expected %h", name, d, fld, act, exp);
    end
  endtask

  // monitor: compare every queued snapshot at the falling edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, e.dut, "addr",     {4'h0, addr[e.dut]}, {4'h0, e.addr});
      cmp(e.name, e.dut, "bit_out",  bit_out[e.dut],      e.bit_out);
      cmp(e.name, e.dut, "byte_out", byte_out[e.dut],     e.byte_out);
      cmp(e.name, e.dut, "loaded",   {7'h0, loaded[e.dut]}, {7'h0, e.loaded});
      cmp(e.name, e.dut, "done",     {7'h0, done[e.dut]},   {7'h0, e.done});
    end
  end

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  int k;

  initial begin
    // reset held across edges with en=1: nothing moves
    en = 1'b1;
    edge1(); push_exp("reset_hold", 0);
    edge1(); push_exp("reset_hold2", 0);
    reset = 1'b1;
    push_exp("pre_edge1", 0);
    k = 0;
    edge1(); k++; push_exp("edge1", k);
    edge1(); k++; push_exp("edge2", k);
    while (k < 5) begin edge1(); k++; push_exp("load", k); end
    // stall at addr 5
    en = 1'b0;
    repeat (3) begin edge1(); push_exp("stall_load", k); end
    en = 1'b1;
    edge1(); k++; push_exp("stall_resume", k);
    while (k < 16) begin edge1(); k++; push_exp("load", k); end
    edge1(); k++; push_exp("edge17", k);
    while (k < 32) begin edge1(); k++; push_exp("stream", k); end
    edge1(); k++; push_exp("edge33", k);
    // mixed enable pattern; LOOP=0 instance must stay halted
    for (int i = 0; i < 8; i++) begin
      en = (i % 3 != 1);
      edge1();
      if (en) k++;
      push_exp("post_pass", k);
    end
    en = 1'b1;
    // asynchronous reset between edges mid-stream
    @(posedge clk); #3;
    reset = 1'b0;
    #1 push_exp("async_reset", 0);
    edge1(); push_exp("async_reset_hold", 0);
    reset = 1'b1;
    push_exp("re_pre_edge1", 0);
    edge1(); push_exp("re_edge1", 1);
    edge1(); push_exp("re_edge2", 2);
    drv_done = 1'b1;
  end

  // bounded completion
  initial begin
    int cyc = 0;
    while (!(drv_done && q.size() == 0) && cyc < 500) begin
      @(negedge clk); cyc++;
    end
    @(negedge clk);
    n_chk++;
    if (!drv_done || q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: driver finished %0d, pending %0d, expected 1 and 0", drv_done, q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
